// File: rtl/ddrctl1_seq.sv
// Initiator-side sequencer for the DdrCtl1 instruction interface: turns 32-bit word
// read/write requests into LA/LD/WRP/RDP instruction bursts and waits for completion.
`timescale 1ns/1ps

`ifndef DdrCtl1_NOP
`define DdrCtl1_NOP 4'h0
`define DdrCtl1_LA0 4'h1
`define DdrCtl1_LA1 4'h2
`define DdrCtl1_LA2 4'h3
`define DdrCtl1_LA3 4'h4
`define DdrCtl1_LD0 4'h5
`define DdrCtl1_LD1 4'h6
`define DdrCtl1_LD2 4'h7
`define DdrCtl1_LD3 4'h8
`define DdrCtl1_RDP 4'h9
`define DdrCtl1_WRP 4'hA
`endif

module ddrctl1_seq #(
    parameter int unsigned TIMEOUT = 4096,
    parameter int unsigned LOW_WIN = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_data,
    output logic        rsp_valid,
    output logic        rsp_err,
    output logic [31:0] rsp_data,
    output logic [11:0] inst,
    output logic        inst_en,
    input  logic [31:0] page,
    input  logic        ready
);

    localparam int unsigned CNT_W = ($clog2(TIMEOUT + 1) > 16) ? $clog2(TIMEOUT + 1) : 16;
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(LOW_WIN - 1);

    typedef enum logic [2:0] {IDLE, LA, LD, ISSUE, WLOW, WHIGH, DONE} state_t;

    state_t           state_q, state_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      data_q, data_d;
    logic             write_q, write_d;
    logic [31:0]      cache_q, cache_d;
    logic             cache_vld_q, cache_vld_d;
    logic [3:0]       la_mask_q, la_mask_d;
    logic [1:0]       ld_idx_q, ld_idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [11:0]      inst_q, inst_d;
    logic             inst_en_q, inst_en_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_err_q, rsp_err_d;
    logic [31:0]      rsp_data_q, rsp_data_d;

    logic             accept;
    logic [3:0]       miss_mask;
    logic [3:0]       src_mask;
    logic [31:0]      src_addr;
    logic [7:0]       src_byte0;
    logic             src_write;
    logic [1:0]       pick;
    logic [1:0]       ld_nxt;
    logic             step;

    function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] k);
        case (k)
            2'd0:    return w[7:0];
            2'd1:    return w[15:8];
            2'd2:    return w[23:16];
            default: return w[31:24];
        endcase
    endfunction

    function automatic logic [3:0] la_op(input logic [1:0] k);
        case (k)
            2'd0:    return `DdrCtl1_LA0;
            2'd1:    return `DdrCtl1_LA1;
            2'd2:    return `DdrCtl1_LA2;
            default: return `DdrCtl1_LA3;
        endcase
    endfunction

    function automatic logic [3:0] ld_op(input logic [1:0] k);
        case (k)
            2'd0:    return `DdrCtl1_LD0;
            2'd1:    return `DdrCtl1_LD1;
            2'd2:    return `DdrCtl1_LD2;
            default: return `DdrCtl1_LD3;
        endcase
    endfunction

    function automatic logic [1:0] first_set(input logic [3:0] m);
        if (m[0])      return 2'd0;
        else if (m[1]) return 2'd1;
        else if (m[2]) return 2'd2;
        else           return 2'd3;
    endfunction

    assign req_ready = (state_q == IDLE) & ready;
    assign accept    = req_valid & req_ready;

    assign inst      = inst_q;
    assign inst_en   = inst_en_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_data  = rsp_data_q;

    // Acceptance and the LA walk share one "pick next instruction" path; in IDLE it
    // looks at the live request, in LA at the latched copy and remaining byte mask.
    always_comb begin
        miss_mask = 4'hF;
        if (cache_vld_q) begin
            miss_mask = {cache_q[31:24] != req_addr[31:24], cache_q[23:16] != req_addr[23:16],
                         cache_q[15:8]  != req_addr[15:8],  cache_q[7:0]   != req_addr[7:0]};
        end
        if (state_q == LA) begin
            src_mask  = la_mask_q;
            src_addr  = addr_q;
            src_byte0 = data_q[7:0];
            src_write = write_q;
        end else begin
            src_mask  = miss_mask;
            src_addr  = req_addr;
            src_byte0 = req_data[7:0];
            src_write = req_write;
        end
        pick = first_set(src_mask);
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        data_d      = data_q;
        write_d     = write_q;
        cache_d     = cache_q;
        cache_vld_d = cache_vld_q;
        la_mask_d   = la_mask_q;
        ld_idx_d    = ld_idx_q;
        cnt_d       = cnt_q;
        inst_d      = {`DdrCtl1_NOP, 8'h00};
        inst_en_d   = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_data_d  = rsp_data_q;
        ld_nxt      = ld_idx_q + 2'd1;
        step        = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    addr_d      = req_addr;
                    data_d      = req_data;
                    write_d     = req_write;
                    // Cache is loaded at acceptance; every abort path invalidates it anyway.
                    cache_d     = req_addr;
                    cache_vld_d = 1'b1;
                    step        = 1'b1;
                end
            end
            LA: step = 1'b1;
            LD: begin
                inst_en_d = 1'b1;
                if (ld_idx_q == 2'd3) begin
                    state_d = ISSUE;
                    inst_d  = {`DdrCtl1_WRP, 8'h00};
                end else begin
                    ld_idx_d = ld_nxt;
                    inst_d   = {ld_op(ld_nxt), byte_of(data_q, ld_nxt)};
                end
            end
            ISSUE: begin
                state_d = WLOW;
                cnt_d   = '0;
            end
            WLOW: begin
                if (!ready) begin
                    state_d = WHIGH;
                    cnt_d   = '0;
                end else if (cnt_q == WIN_LAST) begin
                    state_d     = DONE;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = write_q ? rsp_data_q : page;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WHIGH: begin
                if (ready) begin
                    state_d     = DONE;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = write_q ? rsp_data_q : page;
                end else if (cnt_q == TO_LAST) begin
                    state_d     = DONE;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    cache_vld_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (step) begin
            inst_en_d = 1'b1;
            if (|src_mask) begin
                state_d   = LA;
                la_mask_d = src_mask & ~(4'b0001 << pick);
                inst_d    = {la_op(pick), byte_of(src_addr, pick)};
            end else if (src_write) begin
                state_d  = LD;
                ld_idx_d = 2'd0;
                inst_d   = {`DdrCtl1_LD0, src_byte0};
            end else begin
                state_d = ISSUE;
                inst_d  = {`DdrCtl1_RDP, 8'h00};
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            data_q      <= '0;
            write_q     <= 1'b0;
            cache_q     <= '0;
            cache_vld_q <= 1'b0;
            la_mask_q   <= '0;
            ld_idx_q    <= '0;
            cnt_q       <= '0;
            inst_q      <= {`DdrCtl1_NOP, 8'h00};
            inst_en_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            write_q     <= write_d;
            cache_q     <= cache_d;
            cache_vld_q <= cache_vld_d;
            la_mask_q   <= la_mask_d;
            ld_idx_q    <= ld_idx_d;
            cnt_q       <= cnt_d;
            inst_q      <= inst_d;
            inst_en_q   <= inst_en_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

endmodule

// File: tb/tb_ddrctl1_seq.sv
// Scoreboard bench for ddrctl1_seq: the driver plays client and DdrCtl1 controller,
// a reference model predicts the instruction stream and responses, a monitor compares.
`timescale 1ns/1ps

`ifndef DdrCtl1_NOP
`define DdrCtl1_NOP 4'h0
`define DdrCtl1_LA0 4'h1
`define DdrCtl1_LA1 4'h2
`define DdrCtl1_LA2 4'h3
`define DdrCtl1_LA3 4'h4
`define DdrCtl1_LD0 4'h5
`define DdrCtl1_LD1 4'h6
`define DdrCtl1_LD2 4'h7
`define DdrCtl1_LD3 4'h8
`define DdrCtl1_RDP 4'h9
`define DdrCtl1_WRP 4'hA
`endif

module tb_ddrctl1_seq;

    localparam int unsigned TIMEOUT = 4096;
    localparam int unsigned LOW_WIN = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr, req_data;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_data;
    logic [11:0] inst;
    logic        inst_en;
    logic [31:0] page;
    logic        ready;

    always #5 clock = ~clock;

    ddrctl1_seq #(.TIMEOUT(TIMEOUT), .LOW_WIN(LOW_WIN)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_data(rsp_data),
        .inst(inst), .inst_en(inst_en), .page(page), .ready(ready)
    );

    typedef struct packed { logic [11:0] inst; int unsigned cyc; } exp_inst_t;
    typedef struct packed { logic err; logic [31:0] data; } exp_rsp_t;

    exp_inst_t   exp_inst[$];
    exp_rsp_t    exp_rsp[$];
    int unsigned cyc = 0;
    int unsigned errors = 0;
    int unsigned checks = 0;

    // Reference model: last address the controller was told, and a word memory.
    logic [31:0] m_cache;
    bit          m_valid = 1'b0;
    logic [31:0] m_last_rd = '0;
    logic [31:0] mem[logic [31:0]];
    logic [31:0] exp_page;

    logic [3:0] LA_OP[4] = '{`DdrCtl1_LA0, `DdrCtl1_LA1, `DdrCtl1_LA2, `DdrCtl1_LA3};
    logic [3:0] LD_OP[4] = '{`DdrCtl1_LD0, `DdrCtl1_LD1, `DdrCtl1_LD2, `DdrCtl1_LD3};

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clock) begin
        if (inst_en === 1'b1) begin
            if (exp_inst.size() == 0) begin
                check("inst_unexpected", 32'(inst), 32'hFFFF_FFFF);
            end else begin
                exp_inst_t e;
                e = exp_inst.pop_front();
                check("inst", 32'(inst), 32'(e.inst));
                check("inst_cycle", cyc, e.cyc);
            end
        end else begin
            check("inst_idle", 32'(inst), 32'({`DdrCtl1_NOP, 8'h00}));
        end
        if (rsp_valid === 1'b1) begin
            if (exp_rsp.size() == 0) begin
                check("rsp_unexpected", 32'(rsp_err), 32'hFFFF_FFFF);
            end else begin
                exp_rsp_t r;
                r = exp_rsp.pop_front();
                check("rsp_err", 32'(rsp_err), 32'(r.err));
                check("rsp_data", rsp_data, r.data);
            end
        end
    end

    // mode: 0 = ready stays high, 1 = ready drops then recovers, 2 = ready held low (timeout)
    task automatic accept_req(input bit w, input logic [31:0] a, input logic [31:0] d,
                              input int mode, output int unsigned acc);
        bit got = 1'b0;
        int unsigned idx = 0;
        exp_rsp_t r;
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_data  = d;
        acc = 0;
        for (int i = 0; i < 3000 && !got; i++) begin
            @(negedge clock);
            if (req_ready === 1'b1) got = 1'b1;
        end
        if (!got) begin
            check("accept_timeout", 32'(req_ready), 32'h1);
        end else begin
            acc = cyc;
            for (int k = 0; k < 4; k++) begin
                if (!m_valid || m_cache[8*k +: 8] != a[8*k +: 8]) begin
                    exp_inst.push_back('{{LA_OP[k], a[8*k +: 8]}, acc + 1 + idx});
                    idx++;
                end
            end
            if (w) begin
                for (int k = 0; k < 4; k++) begin
                    exp_inst.push_back('{{LD_OP[k], d[8*k +: 8]}, acc + 1 + idx});
                    idx++;
                end
            end
            exp_inst.push_back('{{(w ? `DdrCtl1_WRP : `DdrCtl1_RDP), 8'h00}, acc + 1 + idx});
            m_cache = a;
            m_valid = 1'b1;
            if (mode == 2) begin
                r = '{1'b1, m_last_rd};
                m_valid = 1'b0;
                exp_page = $urandom;
            end else if (w) begin
                r = '{1'b0, m_last_rd};
                mem[a] = d;
                exp_page = $urandom;
            end else begin
                exp_page = mem.exists(a) ? mem[a] : $urandom;
                mem[a] = exp_page;
                m_last_rd = exp_page;
                r = '{1'b0, exp_page};
            end
            exp_rsp.push_back(r);
        end
        @(posedge clock); #1;
        req_valid = 1'b0;
        req_write = 1'($urandom);
        req_addr  = $urandom;
        req_data  = $urandom;
    endtask

    // Controller side: wait for WRP/RDP, shape ready, then wait for the response pulse.
    task automatic finish_req(input int mode);
        bit seen = 1'b0;
        bit rsp_seen = 1'b0;
        int unsigned issue_cyc = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (inst_en === 1'b1 && (inst[11:8] == `DdrCtl1_WRP || inst[11:8] == `DdrCtl1_RDP))
                seen = 1'b1;
            else begin
                @(posedge clock); #1;
            end
        end
        if (!seen) begin
            check("issue_timeout", 32'(inst_en), 32'h1);
            return;
        end
        issue_cyc = cyc;
        page = exp_page;
        if (mode == 1) begin
            repeat ($urandom_range(0, 2)) begin @(posedge clock); #1; end
            ready = 1'b0;
            repeat ($urandom_range(1, 30)) begin @(posedge clock); #1; end
            ready = 1'b1;
        end else if (mode == 2) begin
            ready = 1'b0;
            for (int i = 0; i < TIMEOUT + 200 && !rsp_seen; i++) begin
                @(posedge clock); #1;
                if (rsp_valid === 1'b1) rsp_seen = 1'b1;
            end
            check("timeout_latency_ok",
                  32'((cyc - issue_cyc >= TIMEOUT) && (cyc - issue_cyc <= TIMEOUT + 4)), 32'h1);
            ready = 1'b1;
        end
        for (int i = 0; i < 50 && !rsp_seen; i++) begin
            @(posedge clock); #1;
            if (rsp_valid === 1'b1) rsp_seen = 1'b1;
        end
        if (!rsp_seen) check("rsp_timeout", 32'(rsp_valid), 32'h1);
        else if (mode == 0)
            check("low_win_latency_ok",
                  32'((cyc - issue_cyc >= LOW_WIN) && (cyc - issue_cyc <= LOW_WIN + 2)), 32'h1);
    endtask

    task automatic do_req(input bit w, input logic [31:0] a, input logic [31:0] d, input int mode);
        int unsigned acc;
        accept_req(w, a, d, mode, acc);
        finish_req(mode);
    endtask

    initial begin
        #600000;
        errors++;
        checks++;
        $display("FAIL watchdog: time limit reached, got no finish expected finish");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned acc, up_cyc, bad;
        logic [31:0] a;
        reset = 1'b1; ready = 1'b0; req_valid = 1'b0; req_write = 1'b0;
        req_addr = '0; req_data = '0; page = '0;
        repeat (3) @(posedge clock);
        #1;
        check("reset_inst", 32'(inst), 32'({`DdrCtl1_NOP, 8'h00}));
        check("reset_inst_en", 32'(inst_en), 32'h0);
        check("reset_req_ready", 32'(req_ready), 32'h0);
        check("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        check("reset_rsp_err", 32'(rsp_err), 32'h0);
        check("reset_rsp_data", rsp_data, 32'h0);
        reset = 1'b0;

        // Controller still initialising: the pending request must wait.
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h002B3F12; req_data = 32'hDDCCBBAA;
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clock);
            if (req_ready !== 1'b0 || inst_en !== 1'b0) bad++;
        end
        check("powerup_hold", bad, 32'h0);
        @(posedge clock); #1;
        ready = 1'b1;
        up_cyc = cyc;
        accept_req(1'b1, 32'h002B3F12, 32'hDDCCBBAA, 1, acc);
        check("powerup_accept_cycle", acc, up_cyc);
        finish_req(1);

        do_req(1'b0, 32'h002B3F12, 32'h0, 0);
        do_req(1'b1, 32'h012B3F12, 32'h2211FFEE, 1);
        do_req(1'b0, 32'h012B3F12, 32'h0, 2);
        do_req(1'b1, 32'h012B3F12, 32'h55667788, 0);
        do_req(1'b0, 32'h012B3F12, 32'h0, 1);

        // Reset sampled at the end of the LD2 cycle of a write.
        accept_req(1'b1, 32'h00000040, 32'hA1B2C3D4, 1, acc);
        bad = 1;
        for (int i = 0; i < 20 && bad != 0; i++) begin
            if (inst_en === 1'b1 && inst[11:8] == `DdrCtl1_LD2) bad = 0;
            else begin @(posedge clock); #1; end
        end
        check("ld2_seen", bad, 32'h0);
        reset = 1'b1;
        @(posedge clock); #1;
        exp_inst.delete();
        exp_rsp.delete();
        m_valid = 1'b0;
        m_last_rd = '0;
        mem.delete(32'h00000040);
        check("midop_reset_inst_en", 32'(inst_en), 32'h0);
        check("midop_reset_rsp_valid", 32'(rsp_valid), 32'h0);
        @(posedge clock); #1;
        reset = 1'b0;
        repeat (10) @(posedge clock);
        #1;
        check("midop_reset_rsp_data", rsp_data, 32'h0);
        do_req(1'b1, 32'h00000040, 32'h0BADF00D, 0);
        do_req(1'b0, 32'h00000040, 32'h0, 1);

        a = 32'h00000040;
        for (int n = 0; n < 60; n++) begin
            for (int k = 0; k < 4; k++)
                if ($urandom_range(0, 2) == 0) a[8*k +: 8] = 8'($urandom);
            do_req(1'($urandom), a, $urandom, int'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) begin @(posedge clock); #1; end
        end

        repeat (8) @(posedge clock);
        #1;
        check("queues_drained", 32'(exp_inst.size() + exp_rsp.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ddrctl1_seq.md
Name: ddrctl1_seq

Overview:
- Initiator-side sequencer for the DdrCtl1 instruction interface.
- Accepts 32-bit word read/write requests over a valid/ready handshake.
- Emits the corresponding DdrCtl1 instruction stream on inst/inst_en: LA0..LA3, then LD0..LD3, then WRP or RDP.
- Tracks the controller's ready line, returns read data captured from page, and frees client logic from the byte-serial instruction protocol.

Parameters:
- TIMEOUT, 4096, cycles allowed in each wait state before the request is aborted with rsp_err.
- LOW_WIN, 4, cycles after WRP/RDP within which ready must fall; otherwise the operation counts as already complete.

Ports:
- clock  in  1  system clock; same clock0 domain as DdrCtl1.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid & req_ready.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  32  word address; byte k goes to LAk, i.e. addr[8k+7:8k].
- req_data  in  32  write data; byte k goes to LDk.
- rsp_valid  out  1  one-cycle pulse at the end of every accepted request.
- rsp_err  out  1  qualifies rsp_valid; 1 = timeout.
- rsp_data  out  32  page captured at completion of a read; held until the next read completes.
- inst  out  12  {opcode[3:0], imm[7:0]}; opcodes are the `DdrCtl1_* defines.
- inst_en  out  1  inst valid this cycle.
- page  in  32  DdrCtl1 page register.
- ready  in  1  DdrCtl1 idle/ready.

Behaviour:
- Reset values:
  - inst = {`DdrCtl1_NOP, 8'h00}, inst_en = 0, req_ready = 0, rsp_valid = 0, rsp_err = 0, rsp_data = 0.
  - Address cache invalid; state IDLE.
- Outputs are registered. inst_en is 1 exactly in the cycles an instruction is driven; otherwise inst = NOP with inst_en = 0.
- req_ready = (state == IDLE) & ready, driven combinationally from the registered state and the ready input.
- A request is accepted on req_valid & req_ready. Addr, data and write are latched at acceptance; request inputs are ignored afterwards.
- States: IDLE, LA, LD, ISSUE, WLOW, WHIGH, DONE.
  - LA: iterate k = 0..3 and emit LAk only when the cache is invalid or cache byte k != new byte k. Skipped bytes cost no cycles. If no byte differs, go straight to LD/ISSUE. On exit, cache := latched addr and cache becomes valid.
  - LD (writes only): emit LD0..LD3, one per cycle, always all four. Reads skip LD.
  - ISSUE: emit WRP or RDP for one cycle.
  - WLOW: wait for ready = 0.
    - If it falls, go to WHIGH.
    - If LOW_WIN cycles pass with ready = 1, go to DONE.
  - WHIGH: wait for ready = 1, then go to DONE.
  - DONE: rsp_valid = 1 for one cycle. For reads, rsp_data <= page sampled this cycle. rsp_err = 0. Return to IDLE.
- Latency, cache miss: write = 10 cycles from acceptance to ISSUE (4 LA + 4 LD + 1 ISSUE, plus the acceptance cycle); read = 6 cycles.
- Timeout: a 16-bit-or-wider counter is cleared on entry to WLOW and WHIGH. If it reaches TIMEOUT in WHIGH, go to DONE with rsp_err = 1, leave rsp_data unchanged, and invalidate the cache.
- Any cycle in LA/LD/ISSUE where ready = 0 is legal and does not stall; the instruction stream is not back-pressured.
- Reset mid-operation:
  - Returns to IDLE, drops inst_en the same cycle it is sampled, and invalidates the cache.
  - No rsp_valid is issued for the aborted request.
- ready low at power-up (controller initialisation): req_ready stays 0 and requests wait.
- Consecutive requests: the earliest the next acceptance can occur is the cycle after DONE.

Test Plan:
- Write 0x002B3F12 <= 0xDDCCBBAA after reset:
  - inst_en sequence is LA0 12, LA1 3F, LA2 2B, LA3 00, LD0 AA, LD1 BB, LD2 CC, LD3 DD, WRP on consecutive cycles.
  - One rsp_valid follows once ready is high again, with rsp_err = 0.
- Read the same address immediately afterwards:
  - No LA instructions; RDP is issued the cycle after acceptance.
  - Controller page = 0xDDCCBBAA gives rsp_data = 0xDDCCBBAA.
- Write to 0x012B3F12 (bank bit changes):
  - Only LA3 01 is emitted, followed by LD0..LD3 (EE, FF, 11, 22) and WRP.
- Hold ready low after RDP for longer than TIMEOUT:
  - rsp_valid with rsp_err = 1 and rsp_data unchanged.
  - The next request re-emits all four LA bytes.
- ready = 0 from reset for 1000 cycles with req_valid held:
  - req_ready stays 0 and inst_en stays 0; the request is accepted in the first cycle ready = 1.
- Assert reset during LD2 of a write:
  - inst_en = 0 the next cycle and no rsp_valid.
  - The following request to the same address emits all LA0..LA3.
